divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 268 ++++++++++++++++++++++++++
 tb/tb_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// IEEE-754 binary32 divider: strobe/ack handshake in and out, multi-cycle
// restoring mantissa division with round-to-nearest-even and gradual underflow.
module divider (
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_a_stb,
  input  logic        input_b_stb,
  input  logic        output_z_ack,
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  output logic        input_a_ack,
  output logic        input_b_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT, DIV_SHIFT,
    DIV_SUB, DIV_DONE, NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] EMIN   = -10'sd126;
  localparam logic signed [9:0] EMAX   = 10'sd127;
  localparam logic signed [9:0] EFLUSH = -10'sd151;
  localparam logic [31:0]       QNAN   = 32'h7FC0_0000;
  localparam logic [4:0]        DIV_LAST = 5'd27;

  state_t             r_state;
  state_t             w_next;

  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_z;
  logic               r_a_ack;
  logic               r_b_ack;
  logic               r_z_stb;
  logic [23:0]        r_a_m;
  logic [23:0]        r_b_m;
  logic [23:0]        r_z_m;
  logic signed [9:0]  r_a_e;
  logic signed [9:0]  r_b_e;
  logic signed [9:0]  r_z_e;
  logic               r_z_s;
  logic               r_guard;
  logic               r_round;
  logic               r_sticky;
  logic [27:0]        r_q;
  logic [24:0]        r_rem;
  logic [4:0]         r_count;

  logic [7:0]         w_a_exp;
  logic [7:0]         w_b_exp;
  logic [22:0]        w_a_frac;
  logic [22:0]        w_b_frac;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_special;
  logic               w_sign;
  logic [31:0]        w_special_z;
  logic [4:0]         w_a_lz;
  logic [4:0]         w_b_lz;
  logic               w_ge;
  logic [23:0]        w_diff;
  logic [7:0]         w_pack_e;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lzc24 = 5'(23 - i);
    end
  endfunction

  assign w_a_exp  = r_a[30:23];
  assign w_b_exp  = r_b[30:23];
  assign w_a_frac = r_a[22:0];
  assign w_b_frac = r_b[22:0];
  assign w_a_nan  = (w_a_exp == 8'hFF) && (w_a_frac != 23'd0);
  assign w_b_nan  = (w_b_exp == 8'hFF) && (w_b_frac != 23'd0);
  assign w_a_inf  = (w_a_exp == 8'hFF) && (w_a_frac == 23'd0);
  assign w_b_inf  = (w_b_exp == 8'hFF) && (w_b_frac == 23'd0);
  assign w_a_zero = (w_a_exp == 8'h00) && (w_a_frac == 23'd0);
  assign w_b_zero = (w_b_exp == 8'h00) && (w_b_frac == 23'd0);
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_sign   = r_a[31] ^ r_b[31];

  assign w_a_lz   = lzc24(r_a_m);
  assign w_b_lz   = lzc24(r_b_m);
  assign w_ge     = r_rem >= {1'b0, r_b_m};
  assign w_diff   = r_rem[23:0] - r_b_m;
  assign w_pack_e = r_z_e[7:0] + 8'd127;

  assign output_z     = r_z;
  assign output_z_stb = r_z_stb;
  assign input_a_ack  = r_a_ack;
  assign input_b_ack  = r_b_ack;

  // Special-operand result, checked in priority order.
  always_comb begin
    w_special_z = 32'h0000_0000;
    if (w_a_nan || w_b_nan)        w_special_z = QNAN;
    else if (w_a_inf && w_b_inf)   w_special_z = QNAN;
    else if (w_a_inf)              w_special_z = {w_sign, 8'hFF, 23'd0};
    else if (w_b_inf)              w_special_z = {w_sign, 31'd0};
    else if (w_a_zero && w_b_zero) w_special_z = QNAN;
    else if (w_b_zero)             w_special_z = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero)             w_special_z = {w_sign, 31'd0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= GET_A;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      GET_A:     if (r_a_ack && input_a_stb) w_next = GET_B;
      GET_B:     if (r_b_ack && input_b_stb) w_next = UNPACK;
      UNPACK:    w_next = SPECIAL;
      SPECIAL:   w_next = w_special ? PUT_Z : NORM_A;
      NORM_A:    w_next = NORM_B;
      NORM_B:    w_next = DIV_INIT;
      DIV_INIT:  w_next = DIV_SHIFT;
      DIV_SHIFT: w_next = DIV_SUB;
      DIV_SUB:   w_next = (r_count == DIV_LAST) ? DIV_DONE : DIV_SHIFT;
      DIV_DONE:  w_next = NORM_1;
      NORM_1:    w_next = NORM_2;
      NORM_2:    if (r_z_e >= EMIN) w_next = ROUND;
      ROUND:     w_next = PACK;
      PACK:      w_next = PUT_Z;
      PUT_Z:     if (r_z_stb && output_z_ack) w_next = GET_A;
      default:   w_next = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_z      <= '0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_z_stb  <= 1'b0;
      r_a_m    <= '0;
      r_b_m    <= '0;
      r_z_m    <= '0;
      r_a_e    <= '0;
      r_b_e    <= '0;
      r_z_e    <= '0;
      r_z_s    <= 1'b0;
      r_guard  <= 1'b0;
      r_round  <= 1'b0;
      r_sticky <= 1'b0;
      r_q      <= '0;
      r_rem    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        GET_A: begin
          r_a_ack <= 1'b1;
          if (r_a_ack && input_a_stb) begin
            r_a     <= input_a;
            r_a_ack <= 1'b0;
          end
        end
        GET_B: begin
          r_b_ack <= 1'b1;
          if (r_b_ack && input_b_stb) begin
            r_b     <= input_b;
            r_b_ack <= 1'b0;
          end
        end
        UNPACK: begin
          r_a_m <= {w_a_exp != 8'd0, w_a_frac};
          r_b_m <= {w_b_exp != 8'd0, w_b_frac};
          r_a_e <= (w_a_exp == 8'd0) ? EMIN : $signed({2'b00, w_a_exp}) - 10'sd127;
          r_b_e <= (w_b_exp == 8'd0) ? EMIN : $signed({2'b00, w_b_exp}) - 10'sd127;
          r_z_s <= w_sign;
        end
        SPECIAL: begin
          if (w_special) r_z <= w_special_z;
        end
        // Denormal operands are normalized in one step by their leading-zero count.
        NORM_A: begin
          r_a_m <= r_a_m << w_a_lz;
          r_a_e <= r_a_e - $signed({5'b00000, w_a_lz});
        end
        NORM_B: begin
          r_b_m <= r_b_m << w_b_lz;
          r_b_e <= r_b_e - $signed({5'b00000, w_b_lz});
        end
        DIV_INIT: begin
          r_z_e   <= r_a_e - r_b_e;
          r_rem   <= {1'b0, r_a_m};
          r_q     <= '0;
          r_count <= '0;
        end
        DIV_SHIFT: begin
          r_q <= {r_q[26:0], 1'b0};
        end
        DIV_SUB: begin
          if (w_ge) begin
            r_rem  <= {w_diff, 1'b0};
            r_q[0] <= 1'b1;
          end else begin
            r_rem  <= {r_rem[23:0], 1'b0};
          end
          r_count <= r_count + 5'd1;
        end
        // q[27] carries weight 1, so the quotient lies in (0.5, 2).
        DIV_DONE: begin
          r_z_m    <= r_q[27:4];
          r_guard  <= r_q[3];
          r_round  <= r_q[2];
          r_sticky <= (|r_q[1:0]) | (|r_rem);
        end
        NORM_1: begin
          if (!r_z_m[23] && (r_z_e > EMIN)) begin
            r_z_m   <= {r_z_m[22:0], r_guard};
            r_guard <= r_round;
            r_round <= 1'b0;
            r_z_e   <= r_z_e - 10'sd1;
          end
        end
        // Past 26 shifts every significant bit has landed in sticky.
        NORM_2: begin
          if (r_z_e < EFLUSH) begin
            r_sticky <= r_sticky | r_round | r_guard | (|r_z_m);
            r_z_m    <= '0;
            r_guard  <= 1'b0;
            r_round  <= 1'b0;
            r_z_e    <= EMIN;
          end else if (r_z_e < EMIN) begin
            r_z_m    <= {1'b0, r_z_m[23:1]};
            r_guard  <= r_z_m[0];
            r_round  <= r_guard;
            r_sticky <= r_sticky | r_round;
            r_z_e    <= r_z_e + 10'sd1;
          end
        end
        ROUND: begin
          if (r_guard && (r_round || r_sticky || r_z_m[0])) begin
            r_z_m <= r_z_m + 24'd1;
            if (r_z_m == 24'hFF_FFFF) r_z_e <= r_z_e + 10'sd1;
          end
        end
        PACK: begin
          if (r_z_e > EMAX)
            r_z <= {r_z_s, 8'hFF, 23'd0};
          else if ((r_z_e == EMIN) && !r_z_m[23])
            r_z <= {r_z_s, 8'h00, r_z_m[22:0]};
          else
            r_z <= {r_z_s, w_pack_e, r_z_m[22:0]};
        end
        PUT_Z: begin
          r_z_stb <= 1'b1;
          if (r_z_stb && output_z_ack) r_z_stb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider: hand-computed quotients, handshake
// timing, hold-without-ack behaviour and asynchronous reset mid-operation.
module tb_divider;

  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        input_a_stb;
  logic        input_b_stb;
  logic        output_z_ack;
  logic        clk;
  logic        rst;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        input_a_ack;
  logic        input_b_ack;

  int checkCount;
  int passCount;

  divider dut (
    .input_a      (input_a),
    .input_b      (input_b),
    .input_a_stb  (input_a_stb),
    .input_b_stb  (input_b_stb),
    .output_z_ack (output_z_ack),
    .clk          (clk),
    .rst          (rst),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .input_a_ack  (input_a_ack),
    .input_b_ack  (input_b_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  // Offers a and b with both strobes held high, waits for the quotient
  // strobe and reports the cycles counted from the capture of b.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] z, output int lat);
    int waitCycles;
    @(negedge clk);
    input_a     = a;
    input_b     = b;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    waitCycles  = 0;
    while (!input_b_ack && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    lat = 0;
    if (input_b_ack) begin
      @(negedge clk);
      lat = 1;
      while (!output_z_stb && lat < 200) begin
        @(negedge clk);
        lat++;
      end
    end
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    checkOutput("z_stb_arrived", 32'(output_z_stb), 32'd1);
    z = output_z;
  endtask

  task automatic consumeOutput(input string tag);
    @(negedge clk);
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    checkOutput({tag, "_stb_drop"}, 32'(output_z_stb), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_a_ack_back"}, 32'(input_a_ack), 32'd1);
  endtask

  logic [31:0] vecA   [12];
  logic [31:0] vecB   [12];
  logic [31:0] vecExp [12];

  initial begin
    logic [31:0] result;
    int          lat;
    int          waitCycles;

    checkCount   = 0;
    passCount    = 0;
    input_a      = '0;
    input_b      = '0;
    input_a_stb  = 1'b0;
    input_b_stb  = 1'b0;
    output_z_ack = 1'b0;
    rst          = 1'b0;

    vecA[0]  = 32'h408CCCCD; vecB[0]  = 32'h400CCCCD; vecExp[0]  = 32'h40000000;
    vecA[1]  = 32'h3F800000; vecB[1]  = 32'h40400000; vecExp[1]  = 32'h3EAAAAAB;
    vecA[2]  = 32'h3F800000; vecB[2]  = 32'h00000000; vecExp[2]  = 32'h7F800000;
    vecA[3]  = 32'hBF800000; vecB[3]  = 32'h00000000; vecExp[3]  = 32'hFF800000;
    vecA[4]  = 32'h00000000; vecB[4]  = 32'h00000000; vecExp[4]  = 32'h7FC00000;
    vecA[5]  = 32'h7FC00000; vecB[5]  = 32'h3F800000; vecExp[5]  = 32'h7FC00000;
    vecA[6]  = 32'h3F800000; vecB[6]  = 32'h7F800000; vecExp[6]  = 32'h00000000;
    vecA[7]  = 32'h00000001; vecB[7]  = 32'h40000000; vecExp[7]  = 32'h00000000;
    vecA[8]  = 32'h7F7FFFFF; vecB[8]  = 32'h3F000000; vecExp[8]  = 32'h7F800000;
    vecA[9]  = 32'hC0C00000; vecB[9]  = 32'h40000000; vecExp[9]  = 32'hC0400000;
    vecA[10] = 32'h00800000; vecB[10] = 32'h40000000; vecExp[10] = 32'h00400000;
    vecA[11] = 32'h3F800000; vecB[11] = 32'hFF800000; vecExp[11] = 32'h80000000;

    #2;
    checkOutput("reset_z",     output_z,            32'h0);
    checkOutput("reset_z_stb", 32'(output_z_stb),   32'd0);
    checkOutput("reset_a_ack", 32'(input_a_ack),    32'd0);
    checkOutput("reset_b_ack", 32'(input_b_ack),    32'd0);

    @(negedge clk);
    rst = 1'b1;
    checkOutput("release_a_ack_low", 32'(input_a_ack), 32'd0);
    @(negedge clk);
    checkOutput("release_a_ack_high", 32'(input_a_ack), 32'd1);

    // First vector also checks that the result holds while unacknowledged.
    applyStimulus(vecA[0], vecB[0], result, lat);
    checkOutput("vec0_z", result, vecExp[0]);
    checkOutput("vec0_latency_ok", 32'(lat <= 120), 32'd1);
    repeat (8) @(negedge clk);
    checkOutput("vec0_hold_stb", 32'(output_z_stb), 32'd1);
    checkOutput("vec0_hold_z",   output_z,          vecExp[0]);
    checkOutput("vec0_hold_a_ack", 32'(input_a_ack), 32'd0);
    consumeOutput("vec0");

    for (int i = 1; i < 12; i++) begin
      applyStimulus(vecA[i], vecB[i], result, lat);
      checkOutput($sformatf("vec%0d_z", i), result, vecExp[i]);
      checkOutput($sformatf("vec%0d_latency_ok", i), 32'(lat <= 120), 32'd1);
      consumeOutput($sformatf("vec%0d", i));
    end

    // Abort a divide in flight once b has been taken.
    @(negedge clk);
    input_a     = 32'h3F800000;
    input_b     = 32'h40400000;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    waitCycles  = 0;
    while (!input_b_ack && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("abort_b_ack_seen", 32'(input_b_ack), 32'd1);
    @(negedge clk);
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_z_stb", 32'(output_z_stb), 32'd0);
    checkOutput("abort_a_ack", 32'(input_a_ack),  32'd0);
    checkOutput("abort_b_ack", 32'(input_b_ack),  32'd0);
    checkOutput("abort_z",     output_z,          32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_a_ack_back", 32'(input_a_ack), 32'd1);
    checkOutput("abort_no_stb",     32'(output_z_stb), 32'd0);

    applyStimulus(32'h40C00000, 32'h40000000, result, lat);
    checkOutput("post_abort_z", result, 32'h40400000);
    consumeOutput("post_abort");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
